// File: rtl/sgc.sv
// Savitzky-Golay smoother: 7-point quadratic least-squares fit.
// Registers coefficients and fitted values one clock after sampling.
module sgc #(
  parameter int WINDOW_SIZE = 7,
  parameter int DEGREE      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WINDOW_SIZE-1:0][31:0] data_window,
  output logic [DEGREE:0][31:0]        polynomial_coefficients,
  output logic [31:0]                  sum_of_weights,
  output logic [WINDOW_SIZE-1:0][31:0] y_values,
  output logic                         out_valid
);

  if (WINDOW_SIZE != 7) begin : g_bad_window
    $error("sgc: WINDOW_SIZE must be 7");
  end
  if (DEGREE != 2) begin : g_bad_degree
    $error("sgc: DEGREE must be 2");
  end

  typedef logic signed [63:0] wide_t;

  // Round to nearest, ties away from zero; d is a positive constant.
  function automatic wide_t rdiv(input wide_t n, input wide_t d);
    wide_t mag;
    wide_t q;
    mag = n[63] ? -n : n;
    q   = (mag + (d >>> 1)) / d;
    return n[63] ? -q : q;
  endfunction

  function automatic logic [31:0] sat32(input wide_t v);
    if (v > 64'sh7FFF_FFFF)
      return 32'h7FFF_FFFF;
    if (v < -64'sh8000_0000)
      return 32'h8000_0000;
    return v[31:0];
  endfunction

  wide_t s   [WINDOW_SIZE];
  wide_t num [WINDOW_SIZE];
  wide_t n0;
  wide_t n1;
  wide_t n2;
  wide_t x;

  always_comb begin
    for (int i = 0; i < WINDOW_SIZE; i++)
      s[i] = wide_t'($signed(data_window[i]));
    n0 = -2*s[0] + 3*s[1] + 6*s[2] + 7*s[3]
       +  6*s[4] + 3*s[5] - 2*s[6];
    n1 = -3*s[0] - 2*s[1] - s[2]
       +    s[4] + 2*s[5] + 3*s[6];
    n2 =  5*s[0] - 3*s[2] - 4*s[3]
       -  3*s[4] + 5*s[6];
    x  = '0;
    // Fitted values use the unrounded numerators over a common 84.
    for (int i = 0; i < WINDOW_SIZE; i++) begin
      x      = wide_t'(i - 3);
      num[i] = 4*n0 + 3*n1*x + n2*x*x;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      polynomial_coefficients <= '0;
      y_values                <= '0;
      sum_of_weights          <= 32'd21;
      out_valid               <= 1'b0;
    end else begin
      polynomial_coefficients[0] <= sat32(rdiv(n0, 21));
      polynomial_coefficients[1] <= sat32(rdiv(n1, 28));
      polynomial_coefficients[2] <= sat32(rdiv(n2, 84));
      for (int i = 0; i < WINDOW_SIZE; i++)
        y_values[i] <= sat32(rdiv(num[i], 84));
      sum_of_weights <= 32'd21;
      out_valid      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sgc.sv
// Bench for sgc: directed table, reset sequences and
// randomized windows against a least-squares reference model.
module tb_sgc;

  logic              clk = 1'b0;
  logic              reset;
  logic [6:0][31:0]  data_window;
  logic [2:0][31:0]  coef;
  logic [31:0]       sow;
  logic [6:0][31:0]  yv;
  logic              valid;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sgc dut (
    .clk                     (clk),
    .reset                   (reset),
    .data_window             (data_window),
    .polynomial_coefficients (coef),
    .sum_of_weights          (sow),
    .y_values                (yv),
    .out_valid               (valid)
  );

  typedef struct {
    string            name;
    logic [6:0][31:0] d;
    logic [2:0][31:0] c;
    logic [6:0][31:0] y;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [6:0][31:0] pk7(input int v [7]);
    logic [6:0][31:0] r;
    for (int i = 0; i < 7; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [2:0][31:0] pk3(input int v [3]);
    logic [2:0][31:0] r;
    for (int i = 0; i < 3; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic longint rnd(input longint n, input longint d);
    if (n >= 0) return (2*n + d) / (2*d);
    return -((-2*n + d) / (2*d));
  endfunction

  function automatic logic [31:0] clamp(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  // Least-squares quadratic over x=-3..3 via the smoothing kernels.
  task automatic model(input logic [6:0][31:0] d,
                       output logic [2:0][31:0] c,
                       output logic [6:0][31:0] y);
    int w0 [7] = '{-2, 3, 6, 7, 6, 3, -2};
    int w1 [7] = '{-3, -2, -1, 0, 1, 2, 3};
    int w2 [7] = '{5, 0, -3, -4, -3, 0, 5};
    longint n0, n1, n2, sv, xx;
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 7; i++) begin
      sv = longint'($signed(d[i]));
      n0 += w0[i] * sv;
      n1 += w1[i] * sv;
      n2 += w2[i] * sv;
    end
    c[0] = clamp(rnd(n0, 21));
    c[1] = clamp(rnd(n1, 28));
    c[2] = clamp(rnd(n2, 84));
    for (int i = 0; i < 7; i++) begin
      xx   = i - 3;
      y[i] = clamp(rnd(4*n0 + 3*n1*xx + n2*xx*xx, 84));
    end
  endtask

  task automatic check(input string name, input logic [2:0][31:0] ec,
                       input logic [6:0][31:0] ey, input logic ev);
    vectors++;
    for (int k = 0; k < 3; k++)
      if (coef[k] !== ec[k]) begin
        miscompares++;
        $display("FAIL %s a%0d got %h want %h", name, k, coef[k], ec[k]);
      end
    for (int k = 0; k < 7; k++)
      if (yv[k] !== ey[k]) begin
        miscompares++;
        $display("FAIL %s y%0d got %h want %h", name, k, yv[k], ey[k]);
      end
    if (sow !== 32'd21) begin
      miscompares++;
      $display("FAIL %s sum_of_weights got %0d want 21", name, sow);
    end
    if (valid !== ev) begin
      miscompares++;
      $display("FAIL %s out_valid got %b want %b", name, valid, ev);
    end
  endtask

  task automatic apply(input logic [6:0][31:0] d);
    @(negedge clk);
    data_window = d;
    @(posedge clk);
    #1;
  endtask

  logic [2:0][31:0] mc;
  logic [6:0][31:0] my;
  logic [6:0][31:0] rd;

  initial begin
    tbl[0] = '{"ramp", pk7('{10, 20, 30, 40, 50, 60, 70}),
               pk3('{40, 10, 0}), pk7('{10, 20, 30, 40, 50, 60, 70})};
    tbl[1] = '{"parabola", pk7('{9, 4, 1, 0, 1, 4, 9}),
               pk3('{0, 0, 1}), pk7('{9, 4, 1, 0, 1, 4, 9})};
    tbl[2] = '{"impulse", pk7('{0, 0, 0, 84, 0, 0, 0}),
               pk3('{28, 0, -4}), pk7('{-8, 12, 24, 28, 24, 12, -8})};
    tbl[3] = '{"constant", pk7('{100, 100, 100, 100, 100, 100, 100}),
               pk3('{100, 0, 0}), pk7('{100, 100, 100, 100, 100, 100, 100})};
    tbl[4] = '{"round_unit", pk7('{0, 0, 0, 1, 0, 0, 0}),
               pk3('{0, 0, 0}), pk7('{0, 0, 0, 0, 0, 0, 0})};
    tbl[5] = '{"all_max",
               pk7('{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                     32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}),
               pk3('{32'h7FFFFFFF, 0, 0}),
               pk7('{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                     32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF})};
    tbl[6] = '{"sat_edges",
               pk7('{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0,
                     32'h80000000, 32'h80000000, 32'h80000000}),
               pk3('{0, 32'hC9249249, 0}),
               pk7('{32'h7FFFFFFF, 32'h6DB6DB6D, 32'h36DB6DB6, 0,
                     32'hC9249249, 32'h92492492, 32'h80000000})};

    reset       = 1'b1;
    data_window = '0;
    #3;
    check("reset_pre_edge", '0, '0, 1'b0);
    #20;
    check("reset_held", '0, '0, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 7; t++) begin
      apply(tbl[t].d);
      check(tbl[t].name, tbl[t].c, tbl[t].y, 1'b1);
    end

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", '0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(tbl[2].d);
    check("post_reset", tbl[2].c, tbl[2].y, 1'b1);

    for (int n = 0; n < 400; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 7; i++) begin
        case (mode)
          0: rd[i] = 32'($urandom_range(0, 4000)) - 32'd2000;
          1: rd[i] = $urandom;
          default: begin
            case ($urandom_range(0, 2))
              0: rd[i] = 32'h7FFF_FFFF;
              1: rd[i] = 32'h8000_0000;
              default: rd[i] = '0;
            endcase
          end
        endcase
      end
      apply(rd);
      model(rd, mc, my);
      check("random", mc, my, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sgc.md
Name: sgc

Overview:
- Savitzky-Golay smoothing core for a 7-sample window.
- Fits a least-squares quadratic over the window. Abscissae are x = -3..+3, with x = i-3 for window index i.
- Outputs the rounded polynomial coefficients, the fit evaluated at every window point, and the smoothing-weight normaliser.
- Sits after a sample shift register. The window is presented in parallel; results are registered one clock later.

Parameters:
- WINDOW_SIZE, 7, samples per window. Only 7 is supported; elaborate-time error otherwise.
- DEGREE, 2, polynomial degree. Only 2 is supported; elaborate-time error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_window  input  32 x WINDOW_SIZE  signed two's-complement samples. Index 0 is the oldest sample (x=-3).
- polynomial_coefficients  output  32 x (DEGREE+1)  signed a0, a1, a2 of p(x)=a0+a1*x+a2*x^2.
- sum_of_weights  output  32  unsigned normaliser of the smoothing kernel.
- y_values  output  32 x WINDOW_SIZE  signed fitted values p(x_i).
- out_valid  output  1  high when the outputs reflect a sampled window.

Behaviour:
- Interface: one clock (clk) and one reset (reset). reset is asynchronous and active-high.
- Reset (asynchronous, active-high):
  - all coefficients, y_values and out_valid go to 0;
  - sum_of_weights goes to 21.
- Each rising clk edge with reset low samples data_window and registers all outputs. Latency is 1 cycle.
- out_valid rises on the first rising edge after reset deasserts and stays high until the next reset.
- There is no handshake. A new window may change every cycle, giving a throughput of 1 per clock.
- Numerators, combinational, with at least 48-bit signed internal width (y indexed by i):
  - N0 = -2y0+3y1+6y2+7y3+6y4+3y5-2y6
  - N1 = -3y0-2y1-y2+y4+2y5+3y6
  - N2 = 5y0-3y2-4y3-3y4+5y6
- Coefficients:
  - a0 = N0/21, a1 = N1/28, a2 = N2/84.
  - Each is rounded to nearest, ties away from zero.
- Fitted values:
  - y_values[i] = (4*N0 + 3*N1*x_i + N2*x_i^2)/84, rounded the same way.
  - These are computed from the unrounded numerators, not from the rounded coefficients.
- Saturation: any result outside the signed 32-bit range saturates to 0x7FFFFFFF or 0x80000000.
- sum_of_weights is the constant 21, the sum of the a0 kernel weights. It is held after reset.
- Reset asserted mid-stream clears the outputs immediately. The next valid result appears 1 cycle after release.
- Division by the constants 21, 28 and 84 may be done by multiply-and-shift, provided the rounding is bit-exact to the rule above.

Test Plan:
- Reset: hold reset, then release.
  - Before the first edge: all outputs 0, sum_of_weights=21, out_valid=0.
  - After the first edge: out_valid=1.
- Linear ramp 10,20,30,40,50,60,70 -> coefficients 40,10,0; y_values 10..70 unchanged; sum_of_weights 21.
- Parabola 9,4,1,0,1,4,9 -> coefficients 0,0,1; y_values 9,4,1,0,1,4,9.
- Impulse 0,0,0,84,0,0,0 -> coefficients 28,0,-4; y_values -8,12,24,28,24,12,-8.
- Constant 100 across all 7 samples -> coefficients 100,0,0; y_values all 100.
- Edge cases:
  - Rounding: impulse of 1 at the centre -> a0=0, y_values[3]=0.
  - Saturation: all samples 0x7FFFFFFF -> a0 and all y_values saturate to 0x7FFFFFFF.
  - Async reset asserted between clock edges clears the outputs without waiting for a clock edge.
